// File: rtl/muldiv_unit_pkg.sv
// Shared CPU definitions for the multiply/divide unit: opcode encodings,
// FSM state encoding and small opcode-decoding helpers.
package muldiv_unit_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned CNT_W    = 6;

  localparam logic [3:0] OP_MUL  = 4'ha;
  localparam logic [3:0] OP_DIV  = 4'hb;
  localparam logic [3:0] OP_MULU = 4'hc;
  localparam logic [3:0] OP_DIVU = 4'hd;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True for the four opcodes this unit executes.
  function automatic logic is_valid_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MULU) || (op == OP_DIVU);
  endfunction

  // True for the two's-complement variants.
  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // True for the division variants.
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-step multiply / restoring-divide unit.
// Magnitudes are processed unsigned; signs are restored in the DONE cycle.
//
// Handshake: start is sampled only while the FSM is IDLE and only together
// with a valid opcode; an accepted request makes busy rise on the next cycle.
// busy stays high through the single DONE cycle, where done pulses for one
// cycle with results valid. There is no ready/back-pressure: a start seen
// while busy, or with any other opcode, is dropped. Results hold until the
// next DONE cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      opcode,
  input  logic [XLEN-1:0] data0,
  input  logic [XLEN-1:0] data1,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] out_hi,
  output logic [XLEN-1:0] out_lo,
  output logic            div_by_zero,
  output state_t          o_dbg_state
);

  state_t                r_state;
  state_t                w_state_nxt;

  logic [2*XLEN-1:0]     r_acc;      // product accumulator / {remainder, quotient}
  logic [XLEN-1:0]       r_opd;      // multiplicand / divisor magnitude
  logic [CNT_W-1:0]      r_cnt;      // iteration counter
  logic                  r_is_div;
  logic                  r_sign0;    // sign of data0 (0 for unsigned ops)
  logic                  r_sign1;    // sign of data1 (0 for unsigned ops)
  logic                  r_dz;       // divisor was zero
  logic [XLEN-1:0]       r_out_hi;
  logic [XLEN-1:0]       r_out_lo;
  logic                  r_out_dz;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_sgn;
  logic [XLEN-1:0]       w_mag0;
  logic [XLEN-1:0]       w_mag1;
  logic [XLEN:0]         w_mul_sum;
  logic [2*XLEN-1:0]     w_mul_next;
  logic [XLEN:0]         w_div_rem;
  logic [XLEN:0]         w_div_diff;
  logic [2*XLEN-1:0]     w_div_next;
  logic [2*XLEN-1:0]     w_prod;
  logic [XLEN-1:0]       w_quo;
  logic [XLEN-1:0]       w_rem;
  logic [XLEN-1:0]       w_res_hi;
  logic [XLEN-1:0]       w_res_lo;

  assign w_accept = (r_state == ST_IDLE) && start && is_valid_op(opcode);
  assign w_last   = (r_cnt == CNT_W'(XLEN - 1));
  assign w_sgn    = is_signed_op(opcode);

  // Magnitudes: -0x80000000 wraps to 0x80000000, read as unsigned 2^31.
  assign w_mag0 = (w_sgn && data0[XLEN-1]) ? -data0 : data0;
  assign w_mag1 = (w_sgn && data1[XLEN-1]) ? -data1 : data1;

  // Shift-add step: add multiplicand into the upper half when the LSB is set,
  // keeping the carry so the shift never loses a bit.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opd};
  assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[XLEN-1:1]}
                               : {1'b0, r_acc[2*XLEN-1:1]};

  // Restoring-divide step: shifted partial remainder is 33 bits wide.
  assign w_div_rem  = r_acc[2*XLEN-1:XLEN-1];
  assign w_div_diff = w_div_rem - {1'b0, r_opd};
  assign w_div_next = w_div_diff[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                       : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  // Sign correction applied in the DONE cycle.
  assign w_prod = (r_sign0 ^ r_sign1) ? -r_acc : r_acc;
  assign w_quo  = r_acc[XLEN-1:0];
  assign w_rem  = r_acc[2*XLEN-1:XLEN];

  // Divide-by-zero leaves |data0| in the remainder, so the normal remainder
  // sign fix reproduces data0; only the quotient is forced.
  always_comb begin
    w_res_hi = '0;
    w_res_lo = '0;
    if (r_is_div) begin
      w_res_hi = r_sign0 ? -w_rem : w_rem;
      if (r_dz) w_res_lo = '1;
      else      w_res_lo = (r_sign0 ^ r_sign1) ? -w_quo : w_quo;
    end else begin
      w_res_hi = w_prod[2*XLEN-1:XLEN];
      w_res_lo = w_prod[XLEN-1:0];
    end
  end

  // State register; reset wins over any start.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)   w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: load on accept, iterate in RUN, capture results in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_opd    <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_sign0  <= 1'b0;
      r_sign1  <= 1'b0;
      r_dz     <= 1'b0;
      r_out_hi <= '0;
      r_out_lo <= '0;
      r_out_dz <= 1'b0;
    end else if (w_accept) begin
      r_is_div <= is_div_op(opcode);
      r_sign0  <= w_sgn & data0[XLEN-1];
      r_sign1  <= w_sgn & data1[XLEN-1];
      r_dz     <= is_div_op(opcode) && (data1 == '0);
      r_cnt    <= '0;
      if (is_div_op(opcode)) begin
        r_acc <= {{XLEN{1'b0}}, w_mag0};
        r_opd <= w_mag1;
      end else begin
        r_acc <= {{XLEN{1'b0}}, w_mag1};
        r_opd <= w_mag0;
      end
    end else if (r_state == ST_RUN) begin
      r_acc <= r_is_div ? w_div_next : w_mul_next;
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (r_state == ST_DONE) begin
      r_out_hi <= w_res_hi;
      r_out_lo <= w_res_lo;
      r_out_dz <= r_dz;
    end
  end

  // Results are live in the DONE cycle, then held from the capture registers.
  assign out_hi      = (r_state == ST_DONE) ? w_res_hi : r_out_hi;
  assign out_lo      = (r_state == ST_DONE) ? w_res_lo : r_out_lo;
  assign div_by_zero = (r_state == ST_DONE) ? r_dz     : r_out_dz;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed vectors, latency, ignored
// requests, reset abort.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  opcode;
  logic [31:0] data0;
  logic [31:0] data1;
  logic        busy;
  logic        done;
  logic [31:0] out_hi;
  logic [31:0] out_lo;
  logic        div_by_zero;
  state_t      o_dbg_state;

  int n_checks;
  int n_errors;

  muldiv_unit #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .opcode      (opcode),
    .data0       (data0),
    .data1       (data1),
    .busy        (busy),
    .done        (done),
    .out_hi      (out_hi),
    .out_lo      (out_lo),
    .div_by_zero (div_by_zero),
    .o_dbg_state (o_dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Advance one cycle and land on the falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a request for one cycle; returns at the negedge of cycle T+1.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    opcode = op;
    data0  = a;
    data1  = b;
    step();
    start  = 1'b0;
    opcode = 4'h0;
  endtask

  // Wait (bounded) for done; lat counts edges after the current negedge.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      step();
      lat++;
    end
    chk("done_seen", {63'b0, done}, 64'd1);
  endtask

  // Issue an op, wait for done, check results, then check pulse/hold.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_dz);
    int lat;
    issue(op, a, b);
    chk({tag, "_busy"}, {63'b0, busy}, 64'd1);
    wait_done(lat);
    chk({tag, "_lat"}, 64'(lat), 64'd32);
    chk({tag, "_res"}, {out_hi, out_lo}, {exp_hi, exp_lo});
    chk({tag, "_dz"}, {63'b0, div_by_zero}, {63'b0, exp_dz});
    step();
    chk({tag, "_pulse"}, {62'b0, done, busy}, 64'd0);
    chk({tag, "_hold"}, {out_hi, out_lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    int lat;
    int n_done;
    n_checks = 0;
    n_errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    opcode = 4'h0;
    data0  = '0;
    data1  = '0;
    @(negedge clk);
    step();

    // Reset state
    chk("rst_outs", {out_hi, out_lo}, 64'd0);
    chk("rst_flags", {61'b0, busy, done, div_by_zero}, 64'd0);
    chk("rst_state", 64'(o_dbg_state), 64'(ST_IDLE));

    // Reset beats a simultaneous start
    issue(OP_MULU, 32'd4, 32'd5);
    chk("rst_prio_busy", {63'b0, busy}, 64'd0);
    rst = 1'b0;
    step();

    // Invalid opcode is ignored
    issue(4'h3, 32'd4, 32'd5);
    chk("badop_busy", {63'b0, busy}, 64'd0);
    step();
    chk("badop_state", 64'(o_dbg_state), 64'(ST_IDLE));

    // Directed vectors
    run_op("mulu_max", OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mul_neg",  OP_MUL,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("mul_min",  OP_MUL,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_op("div_neg",  OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_negd", OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_z",   OP_DIVU, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
    run_op("div_z",    OP_DIV,  32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    run_op("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("divu",     OP_DIVU, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0);

    // Start during busy is dropped: MULU 4*5 at T, MULU 2*3 at T+5
    issue(OP_MULU, 32'd4, 32'd5);            // now at T+1
    for (int i = 0; i < 4; i++) step();      // now at T+5
    issue(OP_MULU, 32'd2, 32'd3);            // now at T+6
    wait_done(lat);
    chk("busy_ign_lat", 64'(lat), 64'd27);
    chk("busy_ign_res", {out_hi, out_lo}, 64'h14);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) n_done++;
    end
    chk("busy_ign_nodone", 64'(n_done), 64'd0);
    chk("busy_ign_idle", {63'b0, busy}, 64'd0);

    // Reset at T+10 of a DIV aborts it
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);     // now at T+1
    for (int i = 0; i < 9; i++) step();      // now at T+10
    chk("abort_busy_pre", {63'b0, busy}, 64'd1);
    rst = 1'b1;
    step();                                  // now at T+11
    rst = 1'b0;
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_outs", {out_hi, out_lo}, 64'd0);
    n_done = 0;
    for (int i = 0; i < 29; i++) begin       // through T+40
      if (done) n_done++;
      step();
    end
    chk("abort_nodone", 64'(n_done), 64'd0);
    chk("abort_final", {30'b0, out_hi, div_by_zero, busy}, 64'd0);
    chk("abort_lo", {32'b0, out_lo}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
